// File: rtl/gps_srq_snap.sv
// GPS service-request / snapshot serializer: captures SRQ, snapshot or missed-epoch state into a
// selected shift register and streams it out MSB-first, one bit per shift strobe; loads take effect next cycle.
module gps_srq_snap #(
  parameter int NCHAN     = 12,
  parameter int REPL_BITS = 16,
  parameter int TICK_BITS = 48,
  parameter int OVF_BITS  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_srq,
  input  logic [NCHAN-1:0]           chan_srq,
  input  logic                       mask_wr,
  input  logic [NCHAN-1:0]           mask_din,
  input  logic [NCHAN*REPL_BITS-1:0] replica,
  input  logic [TICK_BITS-1:0]       ticks,
  input  logic                       load_srq,
  input  logic                       load_snap,
  input  logic                       load_ovf,
  input  logic                       shift,
  output logic                       ser,
  output logic                       pending,
  output logic                       done
);

  localparam int SRQ_LEN  = NCHAN + 1;
  localparam int SNAP_LEN = TICK_BITS + NCHAN + NCHAN*REPL_BITS;
  localparam int OVF_LEN  = NCHAN * OVF_BITS;
  localparam int MAX_A    = (SRQ_LEN > SNAP_LEN) ? SRQ_LEN : SNAP_LEN;
  localparam int MAX_LEN  = (MAX_A > OVF_LEN) ? MAX_A : OVF_LEN;
  localparam int REM_W    = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {SEL_SRQ, SEL_SNAP, SEL_OVF} sel_e;

  logic [NCHAN:0]          r_noted;
  logic [NCHAN-1:0]        r_mask;
  logic [OVF_BITS-1:0]     r_ovf [NCHAN];
  logic [SRQ_LEN-1:0]      r_srq_sr;
  logic [SNAP_LEN-1:0]     r_snap_sr;
  logic [OVF_LEN-1:0]      r_ovf_sr;
  logic [REM_W-1:0]        r_rem;
  sel_e                    r_sel;

  logic [NCHAN:0]          w_req;
  logic [SRQ_LEN-1:0]      w_srq_cap;
  logic [SNAP_LEN-1:0]     w_snap_cap;
  logic [OVF_LEN-1:0]      w_ovf_cat;
  logic [NCHAN-1:0]        w_inc;
  logic                    w_ovf_win;

  assign w_req      = {host_srq, chan_srq};
  assign w_srq_cap  = r_noted & {1'b1, r_mask};
  assign w_snap_cap = {ticks, chan_srq | r_noted[NCHAN-1:0], replica};
  // A repeated epoch only counts as missed if this cycle is not already clearing noted.
  assign w_inc      = chan_srq & r_noted[NCHAN-1:0] & {NCHAN{~load_srq}};
  assign w_ovf_win  = load_ovf & ~load_srq & ~load_snap;

  always_comb begin
    w_ovf_cat = '0;
    for (int i = 0; i < NCHAN; i++) begin
      w_ovf_cat[i*OVF_BITS +: OVF_BITS] = r_ovf[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_noted <= '0;
      r_mask  <= '0;
    end else begin
      if (mask_wr) r_mask <= mask_din;
      if (load_srq) r_noted <= w_req;
      else          r_noted <= r_noted | w_req;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (rst) begin
        r_ovf[i] <= '0;
      end else if (w_ovf_win) begin
        r_ovf[i] <= w_inc[i] ? OVF_BITS'(1) : '0;
      end else if (w_inc[i] && (r_ovf[i] != {OVF_BITS{1'b1}})) begin
        r_ovf[i] <= r_ovf[i] + OVF_BITS'(1);
      end
    end
  end

  // Stream engine: loads win over shift; only the selected register advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_srq_sr  <= '0;
      r_snap_sr <= '0;
      r_ovf_sr  <= '0;
      r_rem     <= '0;
      r_sel     <= SEL_SRQ;
    end else if (load_srq) begin
      r_srq_sr <= w_srq_cap;
      r_rem    <= REM_W'(SRQ_LEN);
      r_sel    <= SEL_SRQ;
    end else if (load_snap) begin
      r_snap_sr <= w_snap_cap;
      r_rem     <= REM_W'(SNAP_LEN);
      r_sel     <= SEL_SNAP;
    end else if (load_ovf) begin
      r_ovf_sr <= w_ovf_cat;
      r_rem    <= REM_W'(OVF_LEN);
      r_sel    <= SEL_OVF;
    end else if (shift && (r_rem != '0)) begin
      r_rem <= r_rem - REM_W'(1);
      case (r_sel)
        SEL_SRQ:  r_srq_sr  <= r_srq_sr << 1;
        SEL_SNAP: r_snap_sr <= r_snap_sr << 1;
        SEL_OVF:  r_ovf_sr  <= r_ovf_sr << 1;
        default:  r_rem     <= '0;
      endcase
    end
  end

  always_comb begin
    ser = 1'b0;
    if (r_rem != '0) begin
      case (r_sel)
        SEL_SRQ:  ser = r_srq_sr[SRQ_LEN-1];
        SEL_SNAP: ser = r_snap_sr[SNAP_LEN-1];
        SEL_OVF:  ser = r_ovf_sr[OVF_LEN-1];
        default:  ser = 1'b0;
      endcase
    end
  end

  assign pending = |w_srq_cap;
  assign done    = (r_rem == '0);

endmodule

// File: tb/tb_gps_srq_snap.sv
// Bench for gps_srq_snap: queue-based reference model compared every cycle, plus directed literal checks.
module tb_gps_srq_snap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_srq = 1'b0;
  logic [3:0]  chan_srq = '0;
  logic        mask_wr = 1'b0;
  logic [3:0]  mask_din = '0;
  logic [15:0] replica = '0;
  logic [7:0]  ticks = '0;
  logic        load_srq = 1'b0;
  logic        load_snap = 1'b0;
  logic        load_ovf = 1'b0;
  logic        shift = 1'b0;
  logic        ser, pending, done;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Reference model state: request bits, mask, counters and the pending bit stream.
  logic [4:0] m_noted = '0;
  logic [3:0] m_mask = '0;
  int         m_ovf [4] = '{0, 0, 0, 0};
  bit         m_q [$];

  gps_srq_snap #(.NCHAN(4), .REPL_BITS(4), .TICK_BITS(8), .OVF_BITS(2)) dut (
    .clk(clk), .rst(rst), .host_srq(host_srq), .chan_srq(chan_srq),
    .mask_wr(mask_wr), .mask_din(mask_din), .replica(replica), .ticks(ticks),
    .load_srq(load_srq), .load_snap(load_snap), .load_ovf(load_ovf), .shift(shift),
    .ser(ser), .pending(pending), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_bits(input logic [63:0] v, input int n);
    m_q.delete();
    for (int k = n - 1; k >= 0; k--) m_q.push_back(v[k]);
  endtask

  task automatic model_step();
    logic [4:0]  old;
    logic [3:0]  inc;
    logic [63:0] v;
    if (rst) begin
      m_noted = '0;
      m_mask  = '0;
      for (int i = 0; i < 4; i++) m_ovf[i] = 0;
      m_q.delete();
    end else begin
      old = m_noted;
      for (int i = 0; i < 4; i++) inc[i] = chan_srq[i] && old[i] && !load_srq;
      v = '0;
      for (int i = 3; i >= 0; i--) v = (v << 2) | 64'(m_ovf[i]);
      if (load_srq) begin
        push_bits(64'(old & {1'b1, m_mask}), 5);
        m_noted = {host_srq, chan_srq};
      end else begin
        m_noted = old | {host_srq, chan_srq};
        if (load_snap) push_bits(64'({ticks, chan_srq | old[3:0], replica}), 28);
        else if (load_ovf) push_bits(v, 8);
        else if (shift && m_q.size() > 0) void'(m_q.pop_front());
      end
      for (int i = 0; i < 4; i++) begin
        if (load_ovf && !load_srq && !load_snap) m_ovf[i] = inc[i] ? 1 : 0;
        else if (inc[i] && m_ovf[i] < 3) m_ovf[i] = m_ovf[i] + 1;
      end
      if (mask_wr) m_mask = mask_din;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ser", 64'(ser), (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
      chk("done", 64'(done), 64'(m_q.size() == 0));
      chk("pending", 64'(pending), 64'(|(m_noted & {1'b1, m_mask})));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    host_srq = 1'b0; chan_srq = '0; mask_wr = 1'b0;
    load_srq = 1'b0; load_snap = 1'b0; load_ovf = 1'b0; shift = 1'b0; rst = 1'b0;
  endtask

  task automatic collect(input int n, output logic [63:0] v);
    v = '0;
    for (int k = 0; k < n; k++) begin
      v = {v[62:0], ser};
      shift = 1'b1;
      cyc();
      shift = 1'b0;
    end
  endtask

  logic [63:0] got;

  initial begin
    rst = 1'b1;
    cyc(); cyc();
    idle();
    chk_en = 1'b1;
    chk("reset_ser", 64'(ser), 64'd0);
    chk("reset_done", 64'(done), 64'd1);
    chk("reset_pending", 64'(pending), 64'd0);

    // Basic SRQ readout
    mask_wr = 1'b1; mask_din = 4'b0101; cyc(); idle();
    chan_srq = 4'b0111; host_srq = 1'b1; cyc(); idle();
    load_srq = 1'b1; cyc(); idle();
    collect(5, got);
    chk("srq_stream", got, 64'b10101);
    chk("srq_done", 64'(done), 64'd1);

    // Request arriving in the load cycle is kept
    load_srq = 1'b1; chan_srq = 4'b0100; cyc(); idle();
    chk("same_cycle_pending", 64'(pending), 64'd1);
    load_srq = 1'b1; cyc(); idle();
    collect(5, got);
    chk("same_cycle_stream", got, 64'b00100);

    // Missed-epoch saturation
    repeat (4) begin chan_srq = 4'b0010; cyc(); end
    idle();
    load_ovf = 1'b1; cyc(); idle();
    collect(8, got);
    chk("ovf_stream", got, 64'b0000_1100);
    load_ovf = 1'b1; cyc(); idle();
    collect(8, got);
    chk("ovf_cleared", got, 64'd0);

    // Snapshot readout
    ticks = 8'hA5; replica = 16'h1234;
    load_snap = 1'b1; cyc(); idle();
    collect(28, got);
    chk("snap_stream", got, 64'hA521234);
    chk("snap_after_ser", 64'(ser), 64'd0);
    shift = 1'b1; cyc(); idle();
    chk("snap_extra_ser", 64'(ser), 64'd0);
    chk("snap_extra_done", 64'(done), 64'd1);

    // Priority restart mid-stream
    chan_srq = 4'b0001; cyc(); idle();
    load_snap = 1'b1; cyc(); idle();
    collect(3, got);
    ticks = 8'h3C;
    load_srq = 1'b1; load_snap = 1'b1; shift = 1'b1; cyc(); idle();
    collect(4, got);
    chk("prio_not_done", 64'(done), 64'd0);
    v_last : begin
      logic [63:0] g2;
      collect(1, g2);
      got = {got[62:0], g2[0]};
    end
    chk("prio_srq_stream", got, 64'b00001);
    chk("prio_done", 64'(done), 64'd1);

    // Reset mid-stream
    repeat (2) begin chan_srq = 4'b0001; cyc(); idle(); end
    load_snap = 1'b1; cyc(); idle();
    collect(3, got);
    rst = 1'b1; load_ovf = 1'b1; shift = 1'b1; cyc(); idle();
    chk("rst_ser", 64'(ser), 64'd0);
    chk("rst_done", 64'(done), 64'd1);
    chk("rst_pending", 64'(pending), 64'd0);
    shift = 1'b1; cyc(); idle();
    chk("rst_shift_ser", 64'(ser), 64'd0);
    load_ovf = 1'b1; cyc(); idle();
    collect(8, got);
    chk("rst_ovf_zero", got, 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(199) == 0);
      host_srq  = ($urandom_range(15) == 0);
      for (int b = 0; b < 4; b++) chan_srq[b] = ($urandom_range(7) == 0);
      mask_wr   = ($urandom_range(19) == 0);
      mask_din  = 4'($urandom);
      replica   = 16'($urandom);
      ticks     = 8'($urandom);
      load_srq  = ($urandom_range(15) == 0);
      load_snap = ($urandom_range(15) == 0);
      load_ovf  = ($urandom_range(15) == 0);
      shift     = ($urandom_range(3) != 0);
      cyc();
    end
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
